regfile_sequencer: RTL and testbench

- Initiator side of the 8x16 register-file port set: drives read indices, write index, write enable and write data, and consumes the two read buses.
- Accepts one micro-op at a time over a valid/ready handshake.
- For each micro-op it reads two source registers, computes a 16-bit ALU result, writes the result back to a destination register, and signals completion.
- Sits between the instruction front-end and the register file in the project datapath.

---
 rtl/regfile_pkg.sv | 7 +
 rtl/regfile_sequencer_if.sv | 29 ++
 rtl/seq_alu.sv | 23 ++
 rtl/regfile_sequencer.sv | 81 ++++++++
 tb/tb_regfile_sequencer.sv | 160 ++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and sizes for the register-file sequencer slice.
package regfile_pkg;
    localparam int WIDTH = 16;
    localparam int IDXW = 3;
    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LDI, OP_MOV, OP_NOP} opcode_t;
    typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} seq_state_t;
endpackage

// File: rtl/regfile_sequencer_if.sv
// regfile_sequencer_if: micro-op handshake plus register-file port bundle.
interface regfile_sequencer_if;
    import regfile_pkg::*;
    logic             instr_valid;
    logic             instr_ready;
    logic [2:0]       opcode;
    logic [IDXW-1:0]  ra;
    logic [IDXW-1:0]  rb;
    logic [IDXW-1:0]  rc;
    logic [WIDTH-1:0] imm;
    logic [IDXW-1:0]  rf_a_index;
    logic [IDXW-1:0]  rf_b_index;
    logic [IDXW-1:0]  rf_c_index;
    logic             rf_we;
    logic [WIDTH-1:0] rf_d_input;
    logic [WIDTH-1:0] rf_a_output;
    logic [WIDTH-1:0] rf_b_output;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
    modport master (
        input  instr_valid, opcode, ra, rb, rc, imm, rf_a_output, rf_b_output,
        output instr_ready, rf_a_index, rf_b_index, rf_c_index, rf_we, rf_d_input, done, result, zero
    );
    modport slave (
        output instr_valid, opcode, ra, rb, rc, imm, rf_a_output, rf_b_output,
        input  instr_ready, rf_a_index, rf_b_index, rf_c_index, rf_we, rf_d_input, done, result, zero
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: combinational 16-bit ALU for the sequencer's EXEC step.
module seq_alu
    import regfile_pkg::*;
(
    input  opcode_t          opcode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] imm_i,
    output logic [WIDTH-1:0] y_o
);
    always_comb begin
        y_o = a_i;
        case (opcode_i)
            OP_ADD:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_LDI:  y_o = imm_i;
            default: y_o = a_i;
        endcase
    end
endmodule

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: 4-cycle read/exec/write sequencer driving an 8x16 register file.
module regfile_sequencer
    import regfile_pkg::*;
(
    input  logic clk,
    input  logic reset,
    regfile_sequencer_if.master bus
);
    seq_state_t       state_q, state_d;
    opcode_t          op_q;
    logic [IDXW-1:0]  ra_q, rb_q, rc_q, c_q;
    logic [WIDTH-1:0] imm_q, a_q, b_q, d_q, result_q, alu_y;
    logic             we_q, done_q, zero_q;
    seq_alu u_alu (.opcode_i(op_q), .a_i(a_q), .b_i(b_q), .imm_i(imm_q), .y_o(alu_y));
    always_ff @(posedge clk) state_q <= reset ? IDLE : state_d;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.instr_valid ? READ : IDLE;
            READ:    state_d = EXEC;
            EXEC:    state_d = WRITE;
            default: state_d = IDLE;
        endcase
    end
    // Write strobe, index and data are registered on entry to WRITE so the bus is glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= OP_ADD;
            ra_q     <= '0;
            rb_q     <= '0;
            rc_q     <= '0;
            imm_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            case (state_q)
                IDLE: if (bus.instr_valid) begin
                    op_q  <= opcode_t'(bus.opcode);
                    ra_q  <= bus.ra;
                    rb_q  <= bus.rb;
                    rc_q  <= bus.rc;
                    imm_q <= bus.imm;
                end
                READ: begin
                    a_q <= bus.rf_a_output;
                    b_q <= bus.rf_b_output;
                end
                EXEC: begin
                    c_q    <= rc_q;
                    d_q    <= alu_y;
                    we_q   <= op_q != OP_NOP;
                    done_q <= 1'b1;
                    if (op_q != OP_NOP) begin
                        result_q <= alu_y;
                        zero_q   <= alu_y == '0;
                    end
                end
                default: begin
                    we_q   <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end
    assign bus.instr_ready = state_q == IDLE;
    assign bus.rf_a_index  = ra_q;
    assign bus.rf_b_index  = rb_q;
    assign bus.rf_c_index  = c_q;
    assign bus.rf_d_input  = d_q;
    // A reset sampled at the WRITE edge must suppress the in-flight write.
    assign bus.rf_we       = we_q & ~reset;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.zero        = zero_q;
endmodule

// File: tb/tb_regfile_sequencer.sv
// tb_regfile_sequencer: directed checks of the sequencer against a behavioural register file.
module tb_regfile_sequencer;
    logic clk = 1'b0;
    logic reset;
    int total = 0;
    int bad = 0;
    int lat, wes;
    logic wd;
    logic [15:0] rf [8];
    regfile_sequencer_if bus ();
    regfile_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) if (bus.rf_we) rf[bus.rf_c_index] <= bus.rf_d_input;
    assign bus.rf_a_output = rf[bus.rf_a_index];
    assign bus.rf_b_output = rf[bus.rf_b_index];

    task automatic run_op(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                          input logic [2:0] c, input logic [15:0] im,
                          output int l, output int w, output logic wdone);
        @(negedge clk);
        bus.opcode = op; bus.ra = a; bus.rb = b; bus.rc = c; bus.imm = im; bus.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        l = 0; w = 0; wdone = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (bus.rf_we) w++;
            if (bus.done) begin
                l = i;
                wdone = bus.rf_we;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.instr_valid = 1'b0; bus.opcode = 3'd0; bus.ra = 3'd0; bus.rb = 3'd0; bus.rc = 3'd0; bus.imm = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++; if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got %b want 1", bus.instr_ready); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", bus.done); end
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL reset_we got %b want 0", bus.rf_we); end
        total++; if (bus.result !== 16'h0) begin bad++; $display("FAIL reset_result got %h want 0000", bus.result); end
        total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL reset_zero got %b want 1", bus.zero); end
        total++; if ({bus.rf_a_index, bus.rf_b_index, bus.rf_c_index} !== 9'd0) begin bad++; $display("FAIL reset_idx got %h want 000", {bus.rf_a_index, bus.rf_b_index, bus.rf_c_index}); end
        total++; if (bus.rf_d_input !== 16'h0) begin bad++; $display("FAIL reset_d got %h want 0000", bus.rf_d_input); end
        reset = 1'b0;
    endtask

    task automatic test_ldi_add();
        run_op(3'd5, 3'd0, 3'd0, 3'd1, 16'h1234, lat, wes, wd);
        total++; if (lat != 3 || wd !== 1'b1) begin bad++; $display("FAIL ldi1_timing got lat=%0d we=%b want lat=3 we=1", lat, wd); end
        total++; if (bus.result !== 16'h1234) begin bad++; $display("FAIL ldi1_result got %h want 1234", bus.result); end
        run_op(3'd5, 3'd0, 3'd0, 3'd2, 16'h0FFF, lat, wes, wd);
        total++; if (lat != 3 || wd !== 1'b1) begin bad++; $display("FAIL ldi2_timing got lat=%0d we=%b want lat=3 we=1", lat, wd); end
        run_op(3'd0, 3'd1, 3'd2, 3'd3, 16'h0, lat, wes, wd);
        total++; if (lat != 3 || wd !== 1'b1) begin bad++; $display("FAIL add_timing got lat=%0d we=%b want lat=3 we=1", lat, wd); end
        total++; if (bus.result !== 16'h2233 || bus.zero !== 1'b0) begin bad++; $display("FAIL add_result got %h z=%b want 2233 z=0", bus.result, bus.zero); end
        @(negedge clk);
        total++; if (rf[3] !== 16'h2233) begin bad++; $display("FAIL add_r3 got %h want 2233", rf[3]); end
    endtask

    task automatic test_sub_wrap();
        run_op(3'd5, 3'd0, 3'd0, 3'd1, 16'h0001, lat, wes, wd);
        run_op(3'd5, 3'd0, 3'd0, 3'd2, 16'h0002, lat, wes, wd);
        run_op(3'd1, 3'd1, 3'd2, 3'd4, 16'h0, lat, wes, wd);
        total++; if (bus.result !== 16'hFFFF || bus.zero !== 1'b0) begin bad++; $display("FAIL sub_result got %h z=%b want ffff z=0", bus.result, bus.zero); end
        run_op(3'd5, 3'd0, 3'd0, 3'd5, 16'hFFFF, lat, wes, wd);
        run_op(3'd0, 3'd5, 3'd1, 3'd6, 16'h0, lat, wes, wd);
        total++; if (bus.result !== 16'h0000 || bus.zero !== 1'b1) begin bad++; $display("FAIL addwrap_result got %h z=%b want 0000 z=1", bus.result, bus.zero); end
        @(negedge clk);
        total++; if (rf[4] !== 16'hFFFF || rf[6] !== 16'h0000) begin bad++; $display("FAIL sub_regs got r4=%h r6=%h want ffff 0000", rf[4], rf[6]); end
    endtask

    task automatic test_same_reg();
        run_op(3'd5, 3'd0, 3'd0, 3'd2, 16'h0005, lat, wes, wd);
        run_op(3'd0, 3'd2, 3'd2, 3'd2, 16'h0, lat, wes, wd);
        total++; if (bus.result !== 16'h000A) begin bad++; $display("FAIL samereg_result got %h want 000a", bus.result); end
        @(negedge clk);
        total++; if (rf[2] !== 16'h000A) begin bad++; $display("FAIL samereg_r2 got %h want 000a", rf[2]); end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            bus.instr_valid = 1'b1; bus.opcode = 3'd5; bus.rc = 3'd4; bus.imm = 16'h0100 + 16'(c);
            total++; if (bus.instr_ready !== ((c % 4) == 0)) begin bad++; $display("FAIL b2b_ready c=%0d got %b want %b", c, bus.instr_ready, (c % 4) == 0); end
            if (c % 4 == 3) begin
                total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL b2b_done c=%0d got %b want 1", c, bus.done); end
            end
        end
        @(negedge clk);
        bus.instr_valid = 1'b0;
        total++; if (rf[4] !== 16'h0108 || bus.result !== 16'h0108) begin bad++; $display("FAIL b2b_last got r4=%h res=%h want 0108 0108", rf[4], bus.result); end
    endtask

    task automatic test_nop();
        run_op(3'd5, 3'd0, 3'd0, 3'd7, 16'hAAAA, lat, wes, wd);
        run_op(3'd7, 3'd1, 3'd2, 3'd7, 16'h5555, lat, wes, wd);
        total++; if (lat != 3 || wes != 0) begin bad++; $display("FAIL nop_timing got lat=%0d we_pulses=%0d want 3 0", lat, wes); end
        total++; if (bus.result !== 16'hAAAA || bus.zero !== 1'b0) begin bad++; $display("FAIL nop_result got %h z=%b want aaaa z=0", bus.result, bus.zero); end
        @(negedge clk);
        total++; if (bus.done !== 1'b0 || bus.rf_we !== 1'b0) begin bad++; $display("FAIL nop_after got done=%b we=%b want 0 0", bus.done, bus.rf_we); end
        total++; if (rf[7] !== 16'hAAAA) begin bad++; $display("FAIL nop_r7 got %h want aaaa", rf[7]); end
    endtask

    task automatic test_reset_midflight();
        run_op(3'd5, 3'd0, 3'd0, 3'd3, 16'h3333, lat, wes, wd);
        @(negedge clk);
        bus.opcode = 3'd0; bus.ra = 3'd1; bus.rb = 3'd2; bus.rc = 3'd3; bus.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++; if (bus.instr_ready !== 1'b1 || bus.done !== 1'b0 || bus.rf_we !== 1'b0) begin bad++; $display("FAIL midrst_ctrl got rdy=%b done=%b we=%b want 1 0 0", bus.instr_ready, bus.done, bus.rf_we); end
        total++; if (bus.result !== 16'h0 || bus.zero !== 1'b1 || bus.rf_a_index !== 3'd0) begin bad++; $display("FAIL midrst_vals got res=%h z=%b ia=%0d want 0000 1 0", bus.result, bus.zero, bus.rf_a_index); end
        reset = 1'b0;
        wes = 0;
        repeat (4) begin @(negedge clk); if (bus.rf_we || bus.done) wes++; end
        total++; if (wes != 0 || rf[3] !== 16'h3333) begin bad++; $display("FAIL midrst_nowrite got pulses=%0d r3=%h want 0 3333", wes, rf[3]); end
        bus.opcode = 3'd5; bus.rc = 3'd3; bus.imm = 16'hBEEF; bus.instr_valid = 1'b1; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; bus.instr_valid = 1'b0;
        total++; if (bus.instr_ready !== 1'b1) begin bad++; $display("FAIL rstvalid_ready got %b want 1", bus.instr_ready); end
        wes = 0;
        repeat (4) begin @(negedge clk); if (bus.rf_we || bus.done) wes++; end
        total++; if (wes != 0 || rf[3] !== 16'h3333) begin bad++; $display("FAIL rstvalid_noaccept got pulses=%0d r3=%h want 0 3333", wes, rf[3]); end
    endtask

    task automatic test_logic();
        run_op(3'd5, 3'd0, 3'd0, 3'd1, 16'hF0F0, lat, wes, wd);
        run_op(3'd5, 3'd0, 3'd0, 3'd2, 16'h0FF0, lat, wes, wd);
        run_op(3'd2, 3'd1, 3'd2, 3'd3, 16'h0, lat, wes, wd);
        total++; if (bus.result !== 16'h00F0) begin bad++; $display("FAIL and_result got %h want 00f0", bus.result); end
        run_op(3'd3, 3'd1, 3'd2, 3'd4, 16'h0, lat, wes, wd);
        total++; if (bus.result !== 16'hFFF0) begin bad++; $display("FAIL or_result got %h want fff0", bus.result); end
        run_op(3'd4, 3'd1, 3'd2, 3'd5, 16'h0, lat, wes, wd);
        total++; if (bus.result !== 16'hFF00) begin bad++; $display("FAIL xor_result got %h want ff00", bus.result); end
        run_op(3'd6, 3'd1, 3'd2, 3'd0, 16'h0, lat, wes, wd);
        total++; if (bus.result !== 16'hF0F0) begin bad++; $display("FAIL mov_result got %h want f0f0", bus.result); end
        @(negedge clk);
        total++; if (rf[0] !== 16'hF0F0 || rf[3] !== 16'h00F0 || rf[4] !== 16'hFFF0 || rf[5] !== 16'hFF00) begin bad++; $display("FAIL logic_regs got r0=%h r3=%h r4=%h r5=%h", rf[0], rf[3], rf[4], rf[5]); end
    endtask

    initial begin
        test_reset();
        test_ldi_add();
        test_sub_wrap();
        test_same_reg();
        test_back_to_back();
        test_nop();
        test_reset_midflight();
        test_logic();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
